lcd_fb_arbiter: RTL and testbench
=================================

Name:
lcd_fb_arbiter

Overview:
- Shares the single LCD frame-buffer write port (ram_wr/ram_addr/ram_data into the OLED RAM source) between two requesters.
  - A CPU pixel-write port.
  - A built-in rectangle-fill engine, used for screen clear and solid boxes.
- Converts fill coordinates to linear addresses, clips them to the panel, and schedules at most one write per clock.
- Sits between the system bus glue and the LCD subsystem's RAM write interface, in the system clock domain.

Parameters:
- WIDTH, 96, panel width in pixels.
- HEIGHT, 64, panel height in pixels.
- ADDR_W, 13, frame-buffer address width; WIDTH*HEIGHT must be <= 2**ADDR_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU write request; held until accepted.
- cpu_addr  in  13  CPU linear pixel address.
- cpu_data  in  16  CPU RGB565 pixel.
- cpu_ack  out  1  combinational grant; transfer occurs when cpu_req & cpu_ack.
- fill_start  in  1  one-cycle pulse that starts a fill.
- fill_x0, fill_x1  in  7 each  inclusive column bounds.
- fill_y0, fill_y1  in  6 each  inclusive row bounds.
- fill_color  in  16  RGB565 fill value.
- fill_busy  out  1  fill engine active.
- fill_done  out  1  one-cycle completion pulse.
- ram_wr  out  1  frame-buffer write strobe (registered).
- ram_addr  out  13  write address (registered).
- ram_data  out  16  write data (registered).

Behaviour:
Reset:
- ram_wr=0, ram_addr=0, ram_data=0, fill_busy=0, fill_done=0.
- FSM goes to IDLE; cpu_ack=0 during the reset cycle.
- Reset mid-fill abandons the fill: no further writes and no fill_done.

Write timing:
- A grant in cycle N produces ram_wr=1 in N+1, with ram_addr/ram_data from the granted source.
- ram_wr=0 in any cycle following a cycle with no grant.
- Throughput is one write per clock.

CPU port:
- cpu_ack = cpu_req & !reset & (CPU wins arbitration).
- A requester holding cpu_req high for k granted cycles gets k writes.
- cpu_addr is not range-checked; it is passed through.

Fill start:
- fill_start is sampled only in IDLE; it is ignored while fill_busy=1.
- On start, bounds are latched and clipped:
  - x1c = min(x1, WIDTH-1)
  - y1c = min(y1, HEIGHT-1)
- Empty rectangle (x0>x1c, y0>y1c, x0>=WIDTH, or y0>=HEIGHT):
  - Go to DONE directly; zero writes.
  - fill_done=1 in the cycle after start; fill_busy stays 0.
- Otherwise go to FILL with cx=x0, cy=y0; fill_busy=1 from the next cycle.

FILL state:
- Each cycle where the fill engine is granted issues a write with addr = cy*WIDTH + cx and data = fill_color.
  - For the default WIDTH, compute as (cy<<6)+(cy<<5)+cx, 13-bit, no overflow: max is 6143.
- Scan order is row-major.
  - If cx==x1c: cx<=x0, cy<=cy+1.
  - Else: cx<=cx+1.
- When the granted pixel is (x1c, y1c), go to DONE.

DONE state:
- Lasts one cycle: fill_done=1, fill_busy=0, then return to IDLE.
- The last pixel's ram_wr coincides with fill_done.

Arbitration (default):
- Fixed priority: CPU over fill.
- While the CPU is granted, the fill stalls with cx/cy held; no pixel is lost or duplicated.
- Simultaneous cpu_req and fill_start in IDLE: the CPU write is granted and the fill is still latched.

Optional Feature:
LCD_ARB_FAIR_EN:
- Defined:
  - In FILL, when both requesters are pending, grants alternate, starting with the CPU.
  - A one-bit last_grant register updates on every contested grant and resets to "fill".
  - This guarantees the fill progresses at least every other cycle under a continuous CPU stream.
- Undefined:
  - Strict CPU priority; a continuous cpu_req starves the fill indefinitely.
  - No last_grant register.

Test Plan:
1. Single CPU write:
   - Stimulus: idle, cpu_req for 1 cycle with cpu_addr=0x0123, cpu_data=0xF800.
   - Response: cpu_ack=1 in that cycle; the next cycle shows ram_wr=1, ram_addr=0x0123, ram_data=0xF800; the cycle after shows ram_wr=0.
2. Basic fill:
   - Stimulus: fill x0=2, y0=1, x1=4, y1=2, color=0x07E0.
   - Response: 6 consecutive writes at addresses 98, 99, 100, 194, 195, 196, all with data 0x07E0; fill_busy high for 6 cycles; a single fill_done coinciding with the write to 196.
3. Contention:
   - Stimulus: during test 2's fill, hold cpu_req for 3 cycles.
   - Response: those 3 cycles write the CPU data; the fill pauses and resumes; the fill still produces exactly 6 writes with the same address set.
   - With LCD_ARB_FAIR_EN: writes alternate CPU/fill.
4. Clipping:
   - Stimulus: x0=94, y0=62, x1=120, y1=63.
   - Response: writes at 6046, 6047, 6142, 6143 only, then fill_done.
5. Empty and ignored starts:
   - Stimulus: x0=5, x1=3.
     - Response: no ram_wr; fill_done one cycle after start; fill_busy never high.
   - Stimulus: fill_start pulsed while busy.
     - Response: ignored; the original fill completes unchanged.
6. Reset mid-fill:
   - Stimulus: assert reset in the 3rd cycle of a 6-pixel fill.
   - Response: the next cycle shows all outputs 0; no further writes; no fill_done.

Source files
------------

// File: rtl/lcd_fb_arbiter.sv
// Frame-buffer write-port arbiter: CPU pixel writes and a clipped rectangle-fill engine.
// Optional macro LCD_ARB_FAIR_EN: alternate grants when both sources contend during a fill.
module lcd_fb_arbiter #(
    parameter int WIDTH  = 96,
    parameter int HEIGHT = 64,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_data,
    output logic              cpu_ack,
    input  logic              fill_start,
    input  logic [6:0]        fill_x0,
    input  logic [6:0]        fill_x1,
    input  logic [5:0]        fill_y0,
    input  logic [5:0]        fill_y1,
    input  logic [15:0]       fill_color,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_data
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    localparam logic [7:0] X_LIM8 = 8'(WIDTH - 1);
    localparam logic [7:0] Y_LIM8 = 8'(HEIGHT - 1);
    localparam logic [6:0] X_LIM  = 7'(WIDTH - 1);
    localparam logic [5:0] Y_LIM  = 6'(HEIGHT - 1);

    state_t            r_state, w_state_next;
    logic [6:0]        r_x0, w_x0_next;
    logic [6:0]        r_x1c, w_x1c_next;
    logic [5:0]        r_y1c, w_y1c_next;
    logic [6:0]        r_cx, w_cx_next;
    logic [5:0]        r_cy, w_cy_next;
    logic [15:0]       r_color, w_color_next;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_data;

    logic              w_fill_pend;
    logic              w_cpu_gnt;
    logic              w_fill_gnt;
    logic [6:0]        w_x1c;
    logic [5:0]        w_y1c;
    logic              w_empty;
    logic [ADDR_W-1:0] w_fill_addr;

    // Compare in 8 bits so the clip test stays meaningful for any panel size.
    assign w_x1c = ({1'b0, fill_x1} > X_LIM8) ? X_LIM : fill_x1;
    assign w_y1c = ({2'b00, fill_y1} > Y_LIM8) ? Y_LIM : fill_y1;
    // x1c/y1c never exceed the panel, so an origin off-panel also lands here.
    assign w_empty = (fill_x0 > w_x1c) | (fill_y0 > w_y1c);

    assign w_fill_addr = ADDR_W'(r_cy) * ADDR_W'(WIDTH) + ADDR_W'(r_cx);
    assign w_fill_pend = (r_state == S_FILL);

`ifdef LCD_ARB_FAIR_EN
    logic r_last_grant;  // 1: CPU won the last contested cycle, 0: fill did
    logic w_contest;

    assign w_contest = cpu_req & w_fill_pend;
    assign w_cpu_gnt = cpu_req & ~reset & (~w_contest | ~r_last_grant);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b0;
        end else if (w_contest) begin
            r_last_grant <= w_cpu_gnt;
        end
    end
`else
    assign w_cpu_gnt = cpu_req & ~reset;
`endif

    assign w_fill_gnt = w_fill_pend & ~reset & ~w_cpu_gnt;

    always_comb begin
        w_state_next = r_state;
        w_x0_next    = r_x0;
        w_x1c_next   = r_x1c;
        w_y1c_next   = r_y1c;
        w_cx_next    = r_cx;
        w_cy_next    = r_cy;
        w_color_next = r_color;
        case (r_state)
            S_IDLE: begin
                if (fill_start) begin
                    w_x0_next    = fill_x0;
                    w_x1c_next   = w_x1c;
                    w_y1c_next   = w_y1c;
                    w_cx_next    = fill_x0;
                    w_cy_next    = fill_y0;
                    w_color_next = fill_color;
                    w_state_next = w_empty ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                if (w_fill_gnt) begin
                    if (r_cx == r_x1c && r_cy == r_y1c) begin
                        w_state_next = S_DONE;
                    end else if (r_cx == r_x1c) begin
                        w_cx_next = r_x0;
                        w_cy_next = r_cy + 6'd1;
                    end else begin
                        w_cx_next = r_cx + 7'd1;
                    end
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_x0    <= '0;
            r_x1c   <= '0;
            r_y1c   <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
            r_color <= '0;
        end else begin
            r_state <= w_state_next;
            r_x0    <= w_x0_next;
            r_x1c   <= w_x1c_next;
            r_y1c   <= w_y1c_next;
            r_cx    <= w_cx_next;
            r_cy    <= w_cy_next;
            r_color <= w_color_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            r_wr <= w_cpu_gnt | w_fill_gnt;
            if (w_cpu_gnt) begin
                r_addr <= cpu_addr;
                r_data <= cpu_data;
            end else if (w_fill_gnt) begin
                r_addr <= w_fill_addr;
                r_data <= r_color;
            end
        end
    end

    assign cpu_ack   = w_cpu_gnt;
    assign fill_busy = (r_state == S_FILL);
    assign fill_done = (r_state == S_DONE);
    assign ram_wr    = r_wr;
    assign ram_addr  = r_addr;
    assign ram_data  = r_data;

endmodule

// File: tb/tb_lcd_fb_arbiter.sv
// Directed, table-driven bench for lcd_fb_arbiter: each row is one clock of inputs and expected outputs.
module tb_lcd_fb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [12:0] cpu_addr;
    logic [15:0] cpu_data;
    logic        cpu_ack;
    logic        fill_start;
    logic [6:0]  fill_x0, fill_x1;
    logic [5:0]  fill_y0, fill_y1;
    logic [15:0] fill_color;
    logic        fill_busy, fill_done;
    logic        ram_wr;
    logic [12:0] ram_addr;
    logic [15:0] ram_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lcd_fb_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ack(cpu_ack),
        .fill_start(fill_start), .fill_x0(fill_x0), .fill_x1(fill_x1),
        .fill_y0(fill_y0), .fill_y1(fill_y1), .fill_color(fill_color),
        .fill_busy(fill_busy), .fill_done(fill_done),
        .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_data(ram_data)
    );

    typedef struct {
        logic        rst;
        logic        req;
        logic [12:0] addr;
        logic [15:0] data;
        logic        start;
        logic [6:0]  x0, x1;
        logic [5:0]  y0, y1;
        logic [15:0] color;
        logic        e_ack, e_wr;
        logic [12:0] e_addr;
        logic [15:0] e_data;
        logic        e_busy, e_done;
        logic        ad;       // compare ram_addr/ram_data in this row
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic req, input logic [12:0] addr,
                                input logic [15:0] data, input logic start,
                                input logic [6:0] x0, input logic [6:0] x1,
                                input logic [5:0] y0, input logic [5:0] y1,
                                input logic [15:0] color, input logic ack, input logic wr,
                                input logic [12:0] eaddr, input logic [15:0] edata,
                                input logic busy, input logic done);
        vec_t v;
        v.rst = rst; v.req = req; v.addr = addr; v.data = data; v.start = start;
        v.x0 = x0; v.x1 = x1; v.y0 = y0; v.y1 = y1; v.color = color;
        v.e_ack = ack; v.e_wr = wr; v.e_addr = eaddr; v.e_data = edata;
        v.e_busy = busy; v.e_done = done; v.ad = wr;
        return v;
    endfunction

    // Idle-input row with given expected outputs.
    function automatic vec_t idl(input logic wr, input logic [12:0] eaddr,
                                 input logic [15:0] edata, input logic busy, input logic done);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, wr, eaddr, edata, busy, done);
    endfunction

    function automatic vec_t fst(input logic [6:0] x0, input logic [6:0] x1,
                                 input logic [5:0] y0, input logic [5:0] y1,
                                 input logic [15:0] color, input logic busy);
        return mk(0, 0, 0, 0, 1, x0, x1, y0, y1, color, 0, 0, 0, 0, busy, 0);
    endfunction

    function automatic vec_t cpu(input logic [12:0] addr, input logic [15:0] data,
                                 input logic ack, input logic wr, input logic [12:0] eaddr,
                                 input logic [15:0] edata, input logic busy);
        return mk(0, 1, addr, data, 0, 0, 0, 0, 0, 0, ack, wr, eaddr, edata, busy, 0);
    endfunction

    task automatic apply(input vec_t v, input int idx);
        logic ok;
        @(posedge clk);
        #1;
        reset = v.rst; cpu_req = v.req; cpu_addr = v.addr; cpu_data = v.data;
        fill_start = v.start; fill_x0 = v.x0; fill_x1 = v.x1;
        fill_y0 = v.y0; fill_y1 = v.y1; fill_color = v.color;
        @(negedge clk);
        checks++;
        ok = (cpu_ack === v.e_ack) && (ram_wr === v.e_wr) &&
             (fill_busy === v.e_busy) && (fill_done === v.e_done) &&
             (!v.ad || ((ram_addr === v.e_addr) && (ram_data === v.e_data)));
        if (!ok) begin
            errors++;
            $display("FAIL vec%0d: got ack=%b wr=%b addr=%0d data=%h busy=%b done=%b, want ack=%b wr=%b addr=%0d data=%h busy=%b done=%b",
                     idx, cpu_ack, ram_wr, ram_addr, ram_data, fill_busy, fill_done,
                     v.e_ack, v.e_wr, v.e_addr, v.e_data, v.e_busy, v.e_done);
        end else begin
            $display("vec%0d ok: ack=%b wr=%b addr=%0d data=%h busy=%b done=%b",
                     idx, cpu_ack, ram_wr, ram_addr, ram_data, fill_busy, fill_done);
        end
    endtask

    initial begin
        vec_t v;
        reset = 1; cpu_req = 1; cpu_addr = 13'h555; cpu_data = 16'h0001;
        fill_start = 0; fill_x0 = 0; fill_x1 = 0; fill_y0 = 0; fill_y1 = 0; fill_color = 0;

        // Reset: everything zero, no grant even with cpu_req high.
        v = mk(1, 1, 13'h555, 16'h0001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); v.ad = 1;
        tbl.push_back(v); tbl.push_back(v);
        // Single CPU write.
        tbl.push_back(cpu(13'h123, 16'hF800, 1, 0, 0, 0, 0));
        tbl.push_back(idl(1, 13'h123, 16'hF800, 0, 0));
        tbl.push_back(idl(0, 0, 0, 0, 0));
        // Basic fill (2..4, 1..2).
        tbl.push_back(fst(2, 4, 1, 2, 16'h07E0, 0));
        tbl.push_back(idl(0, 0, 0, 1, 0));
        tbl.push_back(idl(1, 98, 16'h07E0, 1, 0));
        tbl.push_back(idl(1, 99, 16'h07E0, 1, 0));
        tbl.push_back(idl(1, 100, 16'h07E0, 1, 0));
        tbl.push_back(idl(1, 194, 16'h07E0, 1, 0));
        tbl.push_back(idl(1, 195, 16'h07E0, 1, 0));
        tbl.push_back(idl(1, 196, 16'h07E0, 0, 1));
        tbl.push_back(idl(0, 0, 0, 0, 0));
        // Same fill with a 3-write CPU burst in the middle.
        tbl.push_back(fst(2, 4, 1, 2, 16'h07E0, 0));
        tbl.push_back(idl(0, 0, 0, 1, 0));
        tbl.push_back(idl(1, 98, 16'h07E0, 1, 0));
        tbl.push_back(cpu(13'h0AAA, 16'h1111, 1, 1, 99, 16'h07E0, 1));
`ifdef LCD_ARB_FAIR_EN
        tbl.push_back(cpu(13'h0AAB, 16'h2222, 0, 1, 13'h0AAA, 16'h1111, 1));
        tbl.push_back(cpu(13'h0AAB, 16'h2222, 1, 1, 100, 16'h07E0, 1));
        tbl.push_back(cpu(13'h0AAC, 16'h3333, 0, 1, 13'h0AAB, 16'h2222, 1));
        tbl.push_back(cpu(13'h0AAC, 16'h3333, 1, 1, 194, 16'h07E0, 1));
        tbl.push_back(idl(1, 13'h0AAC, 16'h3333, 1, 0));
        tbl.push_back(idl(1, 195, 16'h07E0, 1, 0));
`else
        tbl.push_back(cpu(13'h0AAB, 16'h2222, 1, 1, 13'h0AAA, 16'h1111, 1));
        tbl.push_back(cpu(13'h0AAC, 16'h3333, 1, 1, 13'h0AAB, 16'h2222, 1));
        tbl.push_back(idl(1, 13'h0AAC, 16'h3333, 1, 0));
        tbl.push_back(idl(1, 100, 16'h07E0, 1, 0));
        tbl.push_back(idl(1, 194, 16'h07E0, 1, 0));
        tbl.push_back(idl(1, 195, 16'h07E0, 1, 0));
`endif
        tbl.push_back(idl(1, 196, 16'h07E0, 0, 1));
        tbl.push_back(idl(0, 0, 0, 0, 0));
        // Clipping at the bottom-right corner.
        tbl.push_back(fst(94, 120, 62, 63, 16'hF81F, 0));
        tbl.push_back(idl(0, 0, 0, 1, 0));
        tbl.push_back(idl(1, 6046, 16'hF81F, 1, 0));
        tbl.push_back(idl(1, 6047, 16'hF81F, 1, 0));
        tbl.push_back(idl(1, 6142, 16'hF81F, 1, 0));
        tbl.push_back(idl(1, 6143, 16'hF81F, 0, 1));
        tbl.push_back(idl(0, 0, 0, 0, 0));
        // Empty rectangles: x0 > x1, and x0 beyond the panel.
        tbl.push_back(fst(5, 3, 0, 0, 16'hFFFF, 0));
        tbl.push_back(idl(0, 0, 0, 0, 1));
        tbl.push_back(idl(0, 0, 0, 0, 0));
        tbl.push_back(fst(100, 120, 0, 0, 16'hFFFF, 0));
        tbl.push_back(idl(0, 0, 0, 0, 1));
        tbl.push_back(idl(0, 0, 0, 0, 0));
        // Starts during FILL and DONE are ignored.
        tbl.push_back(fst(0, 1, 0, 0, 16'hABCD, 0));
        tbl.push_back(fst(10, 20, 3, 4, 16'h5555, 1));
        v = fst(10, 20, 3, 4, 16'h5555, 1); v.e_wr = 1; v.e_addr = 0; v.e_data = 16'hABCD; v.ad = 1;
        tbl.push_back(v);
        v = fst(10, 20, 3, 4, 16'h5555, 0); v.e_wr = 1; v.e_addr = 1; v.e_data = 16'hABCD;
        v.e_done = 1; v.ad = 1;
        tbl.push_back(v);
        tbl.push_back(idl(0, 0, 0, 0, 0));
        tbl.push_back(idl(0, 0, 0, 0, 0));
        // Simultaneous CPU request and fill start in IDLE.
        tbl.push_back(mk(0, 1, 13'h0777, 16'h000F, 1, 0, 0, 5, 5, 16'h1234, 1, 0, 0, 0, 0, 0));
        tbl.push_back(idl(1, 13'h0777, 16'h000F, 1, 0));
        tbl.push_back(idl(1, 480, 16'h1234, 0, 1));
        tbl.push_back(idl(0, 0, 0, 0, 0));

        foreach (tbl[i]) apply(tbl[i], i);

        // Reset in the third FILL cycle abandons the fill.
        apply(fst(2, 4, 1, 2, 16'h07E0, 0), 100);
        apply(idl(0, 0, 0, 1, 0), 101);
        apply(idl(1, 98, 16'h07E0, 1, 0), 102);
        apply(mk(1, 1, 13'h0321, 16'hBEEF, 0, 0, 0, 0, 0, 0, 0, 1, 99, 16'h07E0, 1, 0), 103);
        v = idl(0, 0, 0, 0, 0); v.ad = 1;
        apply(v, 104);
        for (int k = 0; k < 8; k++) apply(idl(0, 0, 0, 0, 0), 105 + k);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
